// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
//
// Requester 0 is the execute stage and requester 1 is the branch/AGU. The block
// registers the winner's operands into the ALU inputs. One cycle later it captures
// the ALU result and flags. It then returns them to the winner over a valid/ready
// response handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake, N = 0/1
//   reqN_a/b/op              request operands and opcode
//   alu_inputA/B, alu_ALUOp  registered operands driven to the ALU
//   alu_ALUResult/negative/zero  combinational ALU outputs
//   respN_valid, resp_ready  response handshake (only the owner's valid rises)
//   resp_result/negative/zero    registered ALU result and flags
//   busy                     high whenever the FSM is not idle
//
// Configuration macro ALU_ARB_FIXED_PRIO_EN:
//   defined   -> requester 0 always wins a tie (no priority pointer)
//   undefined -> round-robin between the two requesters
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_inputA,
  output logic [DATA_W-1:0] alu_inputB,
  output logic [OP_W-1:0]   alu_ALUOp,
  input  logic [DATA_W-1:0] alu_ALUResult,
  input  logic              alu_negative,
  input  logic              alu_zero,
  output logic              resp0_valid,
  output logic              resp1_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_negative,
  output logic              resp_zero,
  output logic              busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              neg_q, neg_d, zero_q, zero_d;
  logic              gnt0, gnt1;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // ptr_q = 1 means requester 1 is favoured on the next tie.
  logic ptr_q, ptr_d;
`endif

  // Grant is evaluated every cycle but only acted upon in idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      gnt0 = ~ptr_q;
      gnt1 = ptr_q;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a  : req0_a;
          b_d     = gnt1 ? req1_b  : req0_b;
          op_d    = gnt1 ? req1_op : req0_op;
          owner_d = gnt1;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d   = gnt0;  // favour whoever was not just served
`endif
          state_d = StIssue;
        end
      end
      StIssue: begin
        res_d   = alu_ALUResult;
        neg_d   = alu_negative;
        zero_d  = alu_zero;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign req0_ready    = (state_q == StIdle) & gnt0;
  assign req1_ready    = (state_q == StIdle) & gnt1;
  assign alu_inputA    = a_q;
  assign alu_inputB    = b_q;
  assign alu_ALUOp     = op_q;
  assign resp0_valid   = (state_q == StResp) & ~owner_q;
  assign resp1_valid   = (state_q == StResp) & owner_q;
  assign resp_result   = res_q;
  assign resp_negative = neg_q;
  assign resp_zero     = zero_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_inputA, alu_inputB, alu_ALUResult;
  logic [3:0]  alu_ALUOp;
  logic        alu_negative, alu_zero;
  logic        resp0_valid, resp1_valid, resp_ready;
  logic [31:0] resp_result;
  logic        resp_negative, resp_zero, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        owner;
    logic [31:0] res;
    logic        neg;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Reference ALU: ADD or SUB, flags taken from the 32-bit result.
  always_comb begin
    alu_ALUResult = (alu_ALUOp == OP_SUB) ? alu_inputA - alu_inputB : alu_inputA + alu_inputB;
  end
  assign alu_negative = alu_ALUResult[31];
  assign alu_zero     = (alu_ALUResult == 32'd0);

  alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_inputA(alu_inputA), .alu_inputB(alu_inputB), .alu_ALUOp(alu_ALUOp),
    .alu_ALUResult(alu_ALUResult), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_negative(resp_negative), .resp_zero(resp_zero),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed response handshake is matched against the queue.
  always @(negedge clk) begin
    exp_t e, got;
    if (!rst && (resp0_valid || resp1_valid) && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got owner %0d result %0h expected no response",
                 resp1_valid, resp_result);
      end else begin
        e   = sb.pop_front();
        got = {resp1_valid, resp_result, resp_negative, resp_zero};
        chk("resp_owner_result_flags", 64'(got), 64'(e));
        chk("resp_onehot", 64'(resp0_valid & resp1_valid), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    step(); step();

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy0", 64'(req0_ready), 64'd0);
    chk("rst_resp0", 64'(resp0_valid), 64'd0);
    chk("rst_resp1", 64'(resp1_valid), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_flags", 64'({resp_negative, resp_zero}), 64'd0);
    chk("rst_aluA", 64'(alu_inputA), 64'd0);
    chk("rst_aluop", 64'(alu_ALUOp), 64'd0);

    // Single req0: 5 + (-7) = -2
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'hFFFF_FFF9; req0_op = OP_ADD;
    sb.push_back('{owner: 1'b0, res: 32'hFFFF_FFFE, neg: 1'b1, zero: 1'b0});
    @(negedge clk);
    chk("t1_rdy0", 64'(req0_ready), 64'd1);
    chk("t1_rdy1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);  // ISSUE
    chk("t1_issue_busy", 64'(busy), 64'd1);
    chk("t1_issue_resp0", 64'(resp0_valid), 64'd0);
    chk("t1_aluA", 64'(alu_inputA), 64'd5);
    chk("t1_aluB", 64'(alu_inputB), 64'hFFFF_FFF9);
    chk("t1_aluop", 64'(alu_ALUOp), 64'(OP_ADD));
    step();
    @(negedge clk);  // RESP
    chk("t1_resp0", 64'(resp0_valid), 64'd1);
    chk("t1_resp1", 64'(resp1_valid), 64'd0);
    step();
    @(negedge clk);  // IDLE again
    chk("t1_idle_resp0", 64'(resp0_valid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_aluA_held", 64'(alu_inputA), 64'd5);

    // Both valid continuously after a fresh reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = OP_SUB;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = OP_ADD;
    for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      sb.push_back('{owner: 1'b0, res: 32'd0, neg: 1'b0, zero: 1'b1});
`else
      if (g % 2 == 0) sb.push_back('{owner: 1'b0, res: 32'd0, neg: 1'b0, zero: 1'b1});
      else            sb.push_back('{owner: 1'b1, res: 32'd3, neg: 1'b0, zero: 1'b0});
`endif
    end
    for (int k = 0; k < 12; k++) begin
      logic e0, e1;
      @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
      e0 = (k % 3 == 0);
      e1 = 1'b0;
`else
      e0 = (k % 3 == 0) && ((k / 3) % 2 == 0);
      e1 = (k % 3 == 0) && ((k / 3) % 2 == 1);
`endif
      chk("t2_rdy0", 64'(req0_ready), 64'(e0));
      chk("t2_rdy1", 64'(req1_ready), 64'(e1));
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // req1 alone with overflow wrap, response held off for 5 cycles
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_op = OP_ADD;
    sb.push_back('{owner: 1'b1, res: 32'h8000_0000, neg: 1'b1, zero: 1'b0});
    @(negedge clk);
    chk("t3_rdy1", 64'(req1_ready), 64'd1);
    chk("t3_rdy0", 64'(req0_ready), 64'd0);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = OP_SUB;
    @(negedge clk);  // ISSUE
    chk("t3_issue_rdy0", 64'(req0_ready), 64'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);  // RESP, held
      chk("t3_hold_resp1", 64'(resp1_valid), 64'd1);
      chk("t3_hold_resp0", 64'(resp0_valid), 64'd0);
      chk("t3_hold_result", 64'(resp_result), 64'h8000_0000);
      chk("t3_hold_neg", 64'(resp_negative), 64'd1);
      chk("t3_hold_rdy0", 64'(req0_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    sb.push_back('{owner: 1'b0, res: 32'd6, neg: 1'b0, zero: 1'b0});
    @(negedge clk);
    chk("t3_release_resp1", 64'(resp1_valid), 64'd1);
    step();
    @(negedge clk);  // IDLE, pending req0 accepted
    chk("t3_after_busy", 64'(busy), 64'd0);
    chk("t3_after_resp1", 64'(resp1_valid), 64'd0);
    chk("t3_after_rdy0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    step();
    step();

    // Reset during ISSUE drops the operation
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_op = OP_SUB;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = OP_ADD;
    @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("t4_rdy0", 64'(req0_ready), 64'd1);
`else
    chk("t4_rdy1", 64'(req1_ready), 64'd1);  // req0 was served last
`endif
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t4_issue_busy", 64'(busy), 64'd1);
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_SUB;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = OP_ADD;
    @(negedge clk);
    chk("t4_rst_busy", 64'(busy), 64'd0);
    chk("t4_rst_resp", 64'({resp0_valid, resp1_valid}), 64'd0);
    chk("t4_rst_result", 64'(resp_result), 64'd0);
    chk("t4_rst_aluA", 64'(alu_inputA), 64'd0);
    chk("t4_ptr_rdy0", 64'(req0_ready), 64'd1);
    chk("t4_ptr_rdy1", 64'(req1_ready), 64'd0);
    sb.push_back('{owner: 1'b0, res: 32'd0, neg: 1'b0, zero: 1'b1});
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();
    step();

    @(negedge clk);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
